imem_burst_responder: RTL and testbench

Memory-side responder for the instruction cache line-fill interface. Accepts a level-held line request (valid + word address), reads the line from a synchronous one-cycle-latency instruction RAM, and returns it as a fixed-length burst of words in ascending order. It flags the final word with a last strobe. Sits between the i-cache miss port and the imem macro, and models configurable initial access latency.

---
 rtl/imem_burst_responder.sv | 129 ++++++++++++
 tb/tb_imem_burst_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imem_burst_responder.sv
// imem_burst_responder: answers an i-cache line-fill request by reading one
// aligned line from a one-cycle-latency instruction RAM. The line comes back as
// a contiguous, ascending burst of words. The last word is flagged, and an
// optional initial access latency is modelled.
module imem_burst_responder #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned ADDR_WIDTH         = 21,
  parameter int unsigned BLOCK_OFFSET_WIDTH = 2,
  parameter int unsigned LATENCY            = 0
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,
  input  logic                  i_Req_Valid,
  input  logic [ADDR_WIDTH-1:0] i_Req_Address,
  output logic                  o_Rsp_Valid,
  output logic                  o_Rsp_Last,
  output logic [DATA_WIDTH-1:0] o_Rsp_Data,
  output logic                  o_RAM_En,
  output logic [ADDR_WIDTH-1:0] o_RAM_Addr,
  input  logic [DATA_WIDTH-1:0] i_RAM_Data,
  output logic                  o_Busy
);

  localparam int unsigned NumBeats = 1 << BLOCK_OFFSET_WIDTH;
  localparam int unsigned BeatW    = BLOCK_OFFSET_WIDTH + 1;
  localparam int unsigned LineW    = ADDR_WIDTH - BLOCK_OFFSET_WIDTH;

  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);
  localparam logic [BeatW-1:0] BeatOne  = BeatW'(1);
  localparam logic [7:0]       WaitLoad = 8'(LATENCY);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StBurst,
    StDrain,
    StRecover
  } state_e;

  state_e           state_q, state_d;
  logic [LineW-1:0] line_q, line_d;      // line address; offset bits are implicit zeros
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_last_q, rsp_last_d;
  logic             ram_en;

  // The offset bits of the request are replaced by the beat index and never read.
  logic unused_req_offset;
  assign unused_req_offset = ^i_Req_Address[BLOCK_OFFSET_WIDTH-1:0];

  // Next-state logic: accept, wait out the latency, stream the line, then a drain and a recover cycle.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    wait_cnt_d = wait_cnt_q;
    beat_d     = beat_q;

    unique case (state_q)
      StIdle: begin
        if (i_Req_Valid) begin
          line_d     = i_Req_Address[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH];
          wait_cnt_d = WaitLoad;
          beat_d     = '0;
          state_d    = (LATENCY > 0) ? StWait : StBurst;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q - 8'd1;
        if (wait_cnt_q == 8'd1) begin
          state_d = StBurst;
        end
      end
      StBurst: begin
        beat_d = beat_q + BeatOne;
        if (beat_q == LastBeat) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StRecover;
      end
      // The request is ignored here so the requester has a cycle to drop it.
      StRecover: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // RAM port and the data for the response registers: reads happen only in BURST.
  always_comb begin
    ram_en      = (state_q == StBurst);
    o_RAM_Addr  = '0;
    rsp_valid_d = ram_en;
    rsp_last_d  = ram_en && (beat_q == LastBeat);
    if (ram_en) begin
      o_RAM_Addr = {line_q, beat_q[BLOCK_OFFSET_WIDTH-1:0]};
    end
  end

  // State and response registers; synchronous active-low reset abandons any burst.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q     <= StIdle;
      line_q      <= '0;
      wait_cnt_q  <= '0;
      beat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      wait_cnt_q  <= wait_cnt_d;
      beat_q      <= beat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign o_RAM_En    = ram_en;
  assign o_Rsp_Valid = rsp_valid_q;
  assign o_Rsp_Last  = rsp_last_q;
  assign o_Rsp_Data  = i_RAM_Data;
  assign o_Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_imem_burst_responder.sv
// Bench for imem_burst_responder. Two instances run side by side: one with
// LATENCY=0 and one with LATENCY=3. Each one gets directed requests and then
// random traffic. A timeline reference model predicts every output in every cycle.
module tb_imem_burst_responder;

  localparam int NumBeats = 4;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic        rst_n     [2];
  logic        req_valid [2];
  logic [20:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_last  [2];
  logic [31:0] rsp_data  [2];
  logic        ram_en    [2];
  logic [20:0] ram_addr  [2];
  logic [31:0] ram_data  [2];
  logic        busy      [2];

  // Reference model state per instance.
  bit          known     [2];
  bit          active    [2];
  int          c0        [2];
  int          idle_from [2];
  logic [20:0] base      [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_burst_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(21), .BLOCK_OFFSET_WIDTH(2), .LATENCY(0)
  ) u_dut_l0 (
    .i_Clk(clk), .i_Reset_n(rst_n[0]), .i_Req_Valid(req_valid[0]),
    .i_Req_Address(req_addr[0]), .o_Rsp_Valid(rsp_valid[0]), .o_Rsp_Last(rsp_last[0]),
    .o_Rsp_Data(rsp_data[0]), .o_RAM_En(ram_en[0]), .o_RAM_Addr(ram_addr[0]),
    .i_RAM_Data(ram_data[0]), .o_Busy(busy[0])
  );

  imem_burst_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(21), .BLOCK_OFFSET_WIDTH(2), .LATENCY(3)
  ) u_dut_l3 (
    .i_Clk(clk), .i_Reset_n(rst_n[1]), .i_Req_Valid(req_valid[1]),
    .i_Req_Address(req_addr[1]), .o_Rsp_Valid(rsp_valid[1]), .o_Rsp_Last(rsp_last[1]),
    .o_Rsp_Data(rsp_data[1]), .o_RAM_En(ram_en[1]), .o_RAM_Addr(ram_addr[1]),
    .i_RAM_Data(ram_data[1]), .o_Busy(busy[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // RAM contents are a fixed function of the address, so every word is distinct.
  function automatic logic [31:0] ram_word(input logic [20:0] a);
    return {a[10:0], a} ^ 32'h5A3C_96E1;
  endfunction

  // One-cycle-latency RAM; returns junk when it is not read.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ram_data[d] <= ram_en[d] ? ram_word(ram_addr[d]) : $urandom;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Predict this cycle's outputs from the acceptance cycle, then advance the model.
  always @(negedge clk) begin
    int          t;
    int          l;
    bit          e_busy, e_en, e_valid, e_last;
    logic [20:0] e_addr;
    for (int d = 0; d < 2; d++) begin
      l = lat_of(d);
      if (known[d]) begin
        t       = cyc - c0[d];
        e_busy  = active[d] && t >= 1 && t <= l + NumBeats + 2;
        e_en    = active[d] && t >= l + 1 && t <= l + NumBeats;
        e_valid = active[d] && t >= l + 2 && t <= l + NumBeats + 1;
        e_last  = active[d] && t == l + NumBeats + 1;
        e_addr  = e_en ? 21'(base[d] + 21'(t - l - 1)) : 21'd0;
        check_eq($sformatf("L%0d c%0d busy", l, cyc), 32'(busy[d]), 32'(e_busy));
        check_eq($sformatf("L%0d c%0d ram_en", l, cyc), 32'(ram_en[d]), 32'(e_en));
        check_eq($sformatf("L%0d c%0d ram_addr", l, cyc), 32'(ram_addr[d]), 32'(e_addr));
        check_eq($sformatf("L%0d c%0d rsp_valid", l, cyc), 32'(rsp_valid[d]), 32'(e_valid));
        check_eq($sformatf("L%0d c%0d rsp_last", l, cyc), 32'(rsp_last[d]), 32'(e_last));
        if (e_valid) begin
          check_eq($sformatf("L%0d c%0d rsp_data", l, cyc), rsp_data[d],
                   ram_word(21'(base[d] + 21'(t - l - 2))));
        end
      end
      if (!rst_n[d]) begin
        known[d]     = 1'b1;
        active[d]    = 1'b0;
        idle_from[d] = cyc + 1;
      end else if (known[d] && cyc >= idle_from[d] && req_valid[d]) begin
        active[d]    = 1'b1;
        c0[d]        = cyc;
        base[d]      = req_addr[d] & ~21'd3;
        idle_from[d] = cyc + l + NumBeats + 3;
      end
    end
  end

  // Hold the given inputs on instance d for n cycles.
  task automatic drive(input int d, input bit r, input bit v, input logic [20:0] a,
                       input int n);
    rst_n[d]     = r;
    req_valid[d] = v;
    req_addr[d]  = a;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic random_traffic(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      drive(d, ($urandom % 100) != 0, ($urandom % 3) != 0, 21'($urandom), 1);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      known[d]     = 1'b0;
      active[d]    = 1'b0;
      c0[d]        = 0;
      idle_from[d] = 0;
      base[d]      = '0;
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_addr[d]  = '0;
    end
    fork
      begin
        drive(0, 1'b0, 1'b0, 21'h0, 3);
        drive(0, 1'b1, 1'b0, 21'h0, 2);
        drive(0, 1'b1, 1'b1, 21'h00040, 6);   // aligned line, held until last beat
        drive(0, 1'b1, 1'b0, 21'h0, 3);
        drive(0, 1'b1, 1'b1, 21'h00007, 6);   // unaligned: reads 0x4..0x7
        drive(0, 1'b1, 1'b0, 21'h0, 3);
        drive(0, 1'b1, 1'b1, 21'h00100, 7);   // held across two bursts
        drive(0, 1'b1, 1'b1, 21'h00200, 7);
        drive(0, 1'b1, 1'b0, 21'h0, 4);
        drive(0, 1'b1, 1'b1, 21'h00300, 1);   // reset in C3 of a burst
        drive(0, 1'b1, 1'b0, 21'h0, 2);
        drive(0, 1'b0, 1'b0, 21'h0, 1);
        drive(0, 1'b1, 1'b0, 21'h0, 2);
        drive(0, 1'b1, 1'b1, 21'h00340, 6);
        drive(0, 1'b1, 1'b0, 21'h0, 3);
        drive(0, 1'b1, 1'b1, 21'h1ABCD, 2);   // dropped in C2, burst still completes
        drive(0, 1'b1, 1'b0, 21'h0, 8);
        random_traffic(0, 2500);
      end
      begin
        drive(1, 1'b0, 1'b0, 21'h0, 3);
        drive(1, 1'b1, 1'b0, 21'h0, 2);
        drive(1, 1'b1, 1'b1, 21'h1F3C4, 9);
        drive(1, 1'b1, 1'b0, 21'h0, 3);
        drive(1, 1'b1, 1'b1, 21'h0FFFF, 2);   // offset bits set, dropped early
        drive(1, 1'b1, 1'b0, 21'h0, 10);
        random_traffic(1, 2500);
      end
    join
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
